// File: rtl/vc_fifo_pkg.sv
// Shared sizing defaults for the virtual-channel input buffer.
`ifndef VC_FIFO_DEFINES
`define VC_FIFO_DEFINES
`define PAYLOAD_SIZE 8
`define ADDR_BITS 8
`define FIFO_LOG2 2
`define NUM_VC 2
`endif

package vc_fifo_pkg;

    localparam int unsigned DefWidth     = `PAYLOAD_SIZE + `ADDR_BITS;
    localparam int unsigned DefNumVc     = `NUM_VC;
    localparam int unsigned DefVcBits    = 1;
    localparam int unsigned DefDepthLog2 = `FIFO_LOG2;

    // Occupancy needs one extra bit so that a completely full VC is representable.
    function automatic int unsigned cnt_width(input int unsigned depth_log2);
        return depth_log2 + 1;
    endfunction

    // Default almost-full threshold: one slot short of full.
    function automatic int unsigned def_af_level(input int unsigned depth_log2);
        return (32'd1 << depth_log2) - 32'd1;
    endfunction

endpackage

// File: rtl/vc_fifo_if.sv
// Push/pop/status bundle between a router port and its VC input buffer.
interface vc_fifo_if
    import vc_fifo_pkg::*;
#(
    parameter int unsigned WIDTH      = DefWidth,
    parameter int unsigned NUM_VC     = DefNumVc,
    parameter int unsigned VC_BITS    = DefVcBits,
    parameter int unsigned DEPTH_LOG2 = DefDepthLog2
);

    logic                                   write;
    logic [VC_BITS-1:0]                     write_vc;
    logic [WIDTH-1:0]                       item_in;
    logic                                   read;
    logic [VC_BITS-1:0]                     read_vc;
    logic [WIDTH-1:0]                       item_out;
    logic [NUM_VC-1:0]                      full;
    logic [NUM_VC-1:0]                      empty;
    logic [NUM_VC-1:0]                      almost_full;
    logic [NUM_VC*cnt_width(DEPTH_LOG2)-1:0] count;
    logic                                   overflow;
    logic                                   underflow;

    modport master (
        output write, write_vc, item_in, read, read_vc,
        input  item_out, full, empty, almost_full, count, overflow, underflow
    );

    modport slave (
        input  write, write_vc, item_in, read, read_vc,
        output item_out, full, empty, almost_full, count, overflow, underflow
    );

endinterface

// File: rtl/vc_fifo_ctrl.sv
// Bookkeeping for one virtual channel: pointers, occupancy and registered flags.
module vc_fifo_ctrl
    import vc_fifo_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = DefDepthLog2,
    parameter int unsigned AF_LEVEL   = def_af_level(DEPTH_LOG2)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    output logic [DEPTH_LOG2-1:0] rd_ptr,
    output logic [DEPTH_LOG2-1:0] wr_ptr,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic [DEPTH_LOG2:0]   count
);

    localparam logic [DEPTH_LOG2:0] Depth = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0]   cnt_q, cnt_d;
    logic                  full_q, empty_q, af_q;

    // Next pointers and occupancy; pointers wrap naturally at DEPTH_LOG2 bits.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // State update; flags are computed from the next count so they never lag count.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= (cnt_d == Depth);
            empty_q  <= (cnt_d == '0);
            af_q     <= (32'(cnt_d) >= AF_LEVEL);
        end
    end

    assign rd_ptr      = rd_ptr_q;
    assign wr_ptr      = wr_ptr_q;
    assign count       = cnt_q;
    assign full        = full_q;
    assign empty       = empty_q;
    assign almost_full = af_q;

endmodule

// File: rtl/vc_fifo.sv
// Multi-VC router input buffer: shared flit storage, per-VC control, head-flit mux.
module vc_fifo
    import vc_fifo_pkg::*;
#(
    parameter int unsigned WIDTH      = DefWidth,
    parameter int unsigned NUM_VC     = DefNumVc,
    parameter int unsigned VC_BITS    = DefVcBits,
    parameter int unsigned DEPTH_LOG2 = DefDepthLog2,
    parameter int unsigned AF_LEVEL   = def_af_level(DEPTH_LOG2),
    parameter int          routerid   = -1
) (
    input logic      clk,
    input logic      reset,
    vc_fifo_if.slave bus
);

    localparam int unsigned Depth = 1 << DEPTH_LOG2;
    localparam int unsigned CntW  = cnt_width(DEPTH_LOG2);

    logic [WIDTH-1:0]      mem_q [NUM_VC][Depth];
    logic [DEPTH_LOG2-1:0] rd_ptr [NUM_VC];
    logic [DEPTH_LOG2-1:0] wr_ptr [NUM_VC];
    logic [CntW-1:0]       cnt [NUM_VC];
    logic [NUM_VC-1:0]     full, empty, almost_full;
    logic [NUM_VC-1:0]     push, pop;
    logic [NUM_VC*CntW-1:0] count_flat;

    logic             wr_vc_ok, rd_vc_ok;
    logic             wr_full, rd_empty;
    logic             actual_read, actual_write;
    logic [WIDTH-1:0] head;
    logic             overflow_q, underflow_q;

    // routerid is a debug tag only; this block merely keeps it referenced.
    if (routerid < -1) begin : g_routerid_tag
    end

    // Decode the VC indices; out-of-range indices match nothing and read as empty.
    always_comb begin
        wr_vc_ok = 1'b0;
        rd_vc_ok = 1'b0;
        wr_full  = 1'b0;
        rd_empty = 1'b1;
        head     = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            if (bus.write_vc == VC_BITS'(v)) begin
                wr_vc_ok = 1'b1;
                wr_full  = full[v];
            end
            if (bus.read_vc == VC_BITS'(v)) begin
                rd_vc_ok = 1'b1;
                rd_empty = empty[v];
                head     = mem_q[v][rd_ptr[v]];
            end
        end
    end

    // Accept logic; a full VC still takes a push when it is popped in the same cycle.
    always_comb begin
        actual_read  = bus.read & rd_vc_ok & ~rd_empty;
        actual_write = bus.write & wr_vc_ok &
                       (~wr_full | (actual_read & (bus.read_vc == bus.write_vc)));
        push = '0;
        pop  = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            push[v] = actual_write & (bus.write_vc == VC_BITS'(v));
            pop[v]  = actual_read & (bus.read_vc == VC_BITS'(v));
        end
    end

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        vc_fifo_ctrl #(
            .DEPTH_LOG2 (DEPTH_LOG2),
            .AF_LEVEL   (AF_LEVEL)
        ) u_ctrl (
            .clk         (clk),
            .reset       (reset),
            .push        (push[v]),
            .pop         (pop[v]),
            .rd_ptr      (rd_ptr[v]),
            .wr_ptr      (wr_ptr[v]),
            .full        (full[v]),
            .empty       (empty[v]),
            .almost_full (almost_full[v]),
            .count       (cnt[v])
        );
    end

    // Flit storage; not cleared by reset, and a push during reset is discarded.
    always_ff @(posedge clk) begin
        for (int v = 0; v < NUM_VC; v++) begin
            if (push[v] && !reset) begin
                mem_q[v][wr_ptr[v]] <= bus.item_in;
            end
        end
    end

    // Sticky protocol-error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_q | (bus.write & ~actual_write);
            underflow_q <= underflow_q | (bus.read & ~actual_read);
        end
    end

    // Pack per-VC occupancy, VC v at slot v.
    always_comb begin
        count_flat = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            count_flat[v*CntW +: CntW] = cnt[v];
        end
    end

    assign bus.item_out    = rd_empty ? '0 : head;
    assign bus.full        = full;
    assign bus.empty       = empty;
    assign bus.almost_full = almost_full;
    assign bus.count       = count_flat;
    assign bus.overflow    = overflow_q;
    assign bus.underflow   = underflow_q;

endmodule

// File: tb/tb_vc_fifo.sv
// Directed bench for vc_fifo with a queue-based reference model checked every cycle.
module tb_vc_fifo;

    localparam int unsigned W   = 16;
    localparam int unsigned NV  = 2;
    localparam int unsigned VB  = 1;
    localparam int unsigned DL  = 2;
    localparam int unsigned DEP = 4;
    localparam int unsigned AF  = 3;
    localparam int unsigned CW  = DL + 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    vc_fifo_if #(.WIDTH(W), .NUM_VC(NV), .VC_BITS(VB), .DEPTH_LOG2(DL)) bus ();

    vc_fifo #(
        .WIDTH      (W),
        .NUM_VC     (NV),
        .VC_BITS    (VB),
        .DEPTH_LOG2 (DL),
        .AF_LEVEL   (AF),
        .routerid   (7)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Reference model: one FIFO queue per VC plus the two sticky flags.
    logic [W-1:0] mq [NV][$];
    bit m_ovf = 1'b0;
    bit m_udf = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit rst, input bit w, input int wvc, input logic [W-1:0] d,
                              input bit r, input int rvc);
        bit rok, wok;
        if (rst) begin
            for (int v = 0; v < NV; v++) mq[v].delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
            return;
        end
        rok = r && (rvc < NV) && (mq[rvc].size() > 0);
        wok = w && (wvc < NV) && ((mq[wvc].size() < DEP) || (rok && rvc == wvc));
        if (w && !wok) m_ovf = 1'b1;
        if (r && !rok) m_udf = 1'b1;
        if (rok) void'(mq[rvc].pop_front());
        if (wok) mq[wvc].push_back(d);
    endtask

    // One clock of stimulus; the model advances on the same edge as the DUT.
    task automatic cyc(input bit rst, input bit w, input int wvc, input logic [W-1:0] d,
                       input bit r, input int rvc);
        reset        = rst;
        bus.write    = w;
        bus.write_vc = VB'(wvc);
        bus.item_in  = d;
        bus.read     = r;
        bus.read_vc  = VB'(rvc);
        @(posedge clk);
        model_step(rst, w, wvc, d, r, rvc);
        #2;
    endtask

    // Compare every output against the model away from the active edge.
    logic [W-1:0]       exp_item;
    logic [NV-1:0]      exp_full, exp_empty, exp_af;
    logic [NV*CW-1:0]   exp_cnt;
    int                 rv;
    always @(negedge clk) begin
        if (chk_en) begin
            rv = int'(bus.read_vc);
            exp_item = '0;
            if (rv < NV && mq[rv].size() > 0) exp_item = mq[rv][0];
            for (int v = 0; v < NV; v++) begin
                exp_full[v]  = (mq[v].size() == DEP);
                exp_empty[v] = (mq[v].size() == 0);
                exp_af[v]    = (mq[v].size() >= AF);
                exp_cnt[v*CW +: CW] = CW'(mq[v].size());
            end
            check("item_out", 32'(bus.item_out), 32'(exp_item));
            check("full", 32'(bus.full), 32'(exp_full));
            check("empty", 32'(bus.empty), 32'(exp_empty));
            check("almost_full", 32'(bus.almost_full), 32'(exp_af));
            check("count", 32'(bus.count), 32'(exp_cnt));
            check("overflow", 32'(bus.overflow), 32'(m_ovf));
            check("underflow", 32'(bus.underflow), 32'(m_udf));
        end
    end

    initial begin
        logic [W-1:0] exp_seq [4];
        bus.write = 1'b0; bus.write_vc = '0; bus.item_in = '0;
        bus.read = 1'b0; bus.read_vc = '0;

        cyc(1, 0, 0, 16'h0, 0, 0);
        chk_en = 1'b1;
        cyc(1, 0, 0, 16'h0, 0, 0);
        check("rst_empty", 32'(bus.empty), 32'h3);
        check("rst_count", 32'(bus.count), 32'h0);
        check("rst_full", 32'(bus.full), 32'h0);

        // Fill VC0 with A1..A4.
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 0, W'(16'hA1 + i), 0, 0);
            if (i == 2) check("af_after_3", 32'(bus.almost_full), 32'h1);
        end
        check("fill_full", 32'(bus.full), 32'h1);
        check("fill_count", 32'(bus.count), 32'h04);
        check("fill_empty", 32'(bus.empty), 32'h2);
        check("fill_head", 32'(bus.item_out), 32'h00A1);

        // Pass-through on a full VC.
        cyc(0, 1, 0, 16'h00A5, 1, 0);
        check("pt_count", 32'(bus.count), 32'h04);
        check("pt_ovf", 32'(bus.overflow), 32'h0);
        check("pt_head", 32'(bus.item_out), 32'h00A2);
        exp_seq[0] = 16'h00A3; exp_seq[1] = 16'h00A4; exp_seq[2] = 16'h00A5; exp_seq[3] = 16'h0;
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 16'h0, 1, 0);
            check("drain_head", 32'(bus.item_out), 32'(exp_seq[i]));
        end
        check("drain_empty", 32'(bus.empty), 32'h3);

        // Overflow on a full VC, then underflow on empty VC1.
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, W'(16'hB1 + i), 0, 0);
        cyc(0, 1, 0, 16'h00B5, 0, 0);
        check("ovf_set", 32'(bus.overflow), 32'h1);
        check("ovf_count", 32'(bus.count), 32'h04);
        check("ovf_no_udf", 32'(bus.underflow), 32'h0);
        cyc(0, 0, 0, 16'h0, 1, 1);
        check("udf_set", 32'(bus.underflow), 32'h1);
        check("ovf_sticky", 32'(bus.overflow), 32'h1);

        // Push VC1 every cycle; pop VC0 until drained, then pop VC1 (pointers wrap).
        for (int i = 0; i < 10; i++) begin
            cyc(0, 1, 1, W'(16'hC0 + i), 1, (i < 4) ? 0 : 1);
        end
        check("il_head", 32'(bus.item_out), 32'h00C6);
        check("il_count", 32'(bus.count), 32'h20);
        exp_seq[0] = 16'h00C7; exp_seq[1] = 16'h00C8; exp_seq[2] = 16'h00C9; exp_seq[3] = 16'h0;
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 16'h0, 1, 1);
            check("il_drain", 32'(bus.item_out), 32'(exp_seq[i]));
        end

        // Push to empty VC1 with a simultaneous pop of VC1.
        cyc(0, 1, 1, 16'h00D1, 1, 1);
        check("pte_count", 32'(bus.count), 32'h08);
        check("pte_empty", 32'(bus.empty), 32'h1);
        check("pte_head", 32'(bus.item_out), 32'h00D1);

        // Partial fill, then reset together with a push.
        cyc(0, 1, 0, 16'h00E1, 0, 0);
        cyc(0, 1, 0, 16'h00E2, 0, 0);
        cyc(0, 1, 1, 16'h00E3, 0, 0);
        check("pre_rst_count", 32'(bus.count), 32'h12);
        cyc(1, 1, 0, 16'h00EE, 0, 0);
        check("mrst_count", 32'(bus.count), 32'h0);
        check("mrst_empty", 32'(bus.empty), 32'h3);
        check("mrst_ovf", 32'(bus.overflow), 32'h0);
        check("mrst_udf", 32'(bus.underflow), 32'h0);
        check("mrst_item", 32'(bus.item_out), 32'h0);
        cyc(0, 0, 0, 16'h0, 0, 0);
        check("post_rst_empty", 32'(bus.empty), 32'h3);
        check("post_rst_item", 32'(bus.item_out), 32'h0);
        cyc(0, 1, 1, 16'h00F1, 0, 1);
        check("post_rst_push", 32'(bus.item_out), 32'h00F1);
        cyc(0, 0, 0, 16'h0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
